// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO remote-terminal message engine:
// command word layout, FSM encoding and word-count decoding.
package mkio_pkg;

    typedef struct packed {
        logic [4:0] addr;
        logic       k;
        logic [4:0] sa;
        logic [4:0] wc;
    } cmd_t;

    localparam logic [4:0] BCAST_ADDR = 5'd31;
    localparam int         SW_ME_BIT  = 10;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RX_DATA = 4'd1;
    localparam logic [3:0] ST_GAP     = 4'd2;
    localparam logic [3:0] ST_SEND_SW = 4'd3;
    localparam logic [3:0] ST_SW_HOLD = 4'd4;
    localparam logic [3:0] ST_TX_WAIT = 4'd5;
    localparam logic [3:0] ST_TX_READ = 4'd6;
    localparam logic [3:0] ST_TX_SEND = 4'd7;
    localparam logic [3:0] ST_TX_HOLD = 4'd8;
    localparam logic [3:0] ST_DONE    = 4'd9;

    // A word count field of zero encodes a full 32-word transfer.
    function automatic logic [5:0] wc_to_n(input logic [4:0] wc);
        return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
    endfunction

endpackage

// File: rtl/mkio_rt_buf.sv
// Simple dual-port word buffer: one write port, one registered read port.
// Contents are never cleared; only the read register resets.
module mkio_rt_buf
    import mkio_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];
    logic [15:0] rdata_d;
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 16'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mkio_rt_responder.sv
// MKIO remote-terminal message engine: decodes commands, stores received
// data, answers with status words and streams transmit data to the encoder.
module mkio_rt_responder
    import mkio_pkg::*;
#(
    parameter logic [4:0] ADDRESS    = 5'd1,
    parameter int         SA_NUM     = 4,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 64,
    parameter bit         BCAST_EN   = 1'b1,
    localparam int        AW         = $clog2(SA_NUM) + 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [15:0]   rx_data,
    input  logic          rx_cd,
    input  logic          p_error,
    output logic [15:0]   tx_data,
    output logic          tx_cd,
    output logic          tx_ready,
    input  logic          tx_busy,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [15:0]   host_wdata,
    output logic [15:0]   host_rdata,
    output logic          busy,
    output logic          msg_done,
    output logic          msg_err,
    output logic [4:0]    msg_sa,
    output logic [5:0]    msg_wc
);

    localparam int TW = 16;

    logic [3:0]    state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    n_q, n_d;
    logic [4:0]    sa_q, sa_d;
    logic          k_q, k_d;
    logic          bcast_q, bcast_d;
    logic          illegal_q, illegal_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   tx_data_q, tx_data_d;
    logic          tx_cd_q, tx_cd_d;
    logic          tx_ready_d;

    cmd_t          cmd;
    logic          cmd_bcast;
    logic          cmd_accept;
    logic          cmd_illegal;
    logic          can_supersede;
    logic          data_strobe;
    logic          rx_we;
    logic [AW-1:0] buf_addr;
    logic [15:0]   tx_rdata;
    logic [15:0]   status_word;

    assign cmd           = cmd_t'(rx_data);
    assign cmd_bcast     = BCAST_EN && (cmd.addr == BCAST_ADDR);
    // Broadcast transmit requests are meaningless and are dropped outright.
    assign cmd_accept    = rx_valid && rx_cd && !p_error
                           && ((cmd.addr == ADDRESS) || cmd_bcast)
                           && !(cmd_bcast && cmd.k);
    assign cmd_illegal   = (cmd.sa == 5'd0) || (cmd.sa == 5'd31) || (cmd.sa > 5'(SA_NUM));
    assign can_supersede = state_q inside {ST_IDLE, ST_RX_DATA, ST_GAP, ST_DONE};
    assign data_strobe   = rx_valid && !rx_cd;
    assign rx_we         = (state_q == ST_RX_DATA) && data_strobe && !reset;
    assign buf_addr      = AW'({sa_q - 5'd1, cnt_q[4:0]});

    always_comb begin
        status_word            = 16'd0;
        status_word[15:11]     = ADDRESS;
        status_word[SW_ME_BIT] = err_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        sa_d       = sa_q;
        k_d        = k_q;
        bcast_d    = bcast_q;
        illegal_d  = illegal_q;
        err_d      = err_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        tx_cd_d    = tx_cd_q;
        tx_ready_d = 1'b0;

        case (state_q)
            ST_RX_DATA: begin
                if (data_strobe) begin
                    cnt_d   = cnt_q + 6'd1;
                    timer_d = '0;
                    if (p_error) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q + 6'd1 == n_q) begin
                        state_d = bcast_q ? ST_DONE : ST_GAP;
                    end
                end else if (timer_q >= TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (timer_q >= TW'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = ST_SEND_SW;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SEND_SW: begin
                if (!tx_busy) begin
                    tx_ready_d = 1'b1;
                    tx_data_d  = status_word;
                    tx_cd_d    = 1'b0;
                    state_d    = ST_SW_HOLD;
                end
            end
            ST_SW_HOLD: state_d = (k_q && !illegal_q) ? ST_TX_WAIT : ST_DONE;
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    state_d = ST_TX_READ;
                end
            end
            ST_TX_READ: state_d = ST_TX_SEND;
            ST_TX_SEND: begin
                tx_ready_d = 1'b1;
                tx_data_d  = tx_rdata;
                tx_cd_d    = 1'b1;
                cnt_d      = cnt_q + 6'd1;
                state_d    = ST_TX_HOLD;
            end
            ST_TX_HOLD: state_d = (cnt_q < n_q) ? ST_TX_WAIT : ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // A fresh command wins over whatever the receive side was doing.
        if (cmd_accept && can_supersede) begin
            sa_d      = cmd.sa;
            k_d       = cmd.k;
            bcast_d   = cmd_bcast;
            illegal_d = cmd_illegal;
            err_d     = cmd_illegal;
            n_d       = wc_to_n(cmd.wc);
            cnt_d     = 6'd0;
            timer_d   = '0;
            if (cmd_illegal) begin
                state_d = cmd_bcast ? ST_DONE : ST_GAP;
            end else begin
                state_d = cmd.k ? ST_GAP : ST_RX_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            n_q       <= 6'd0;
            sa_q      <= 5'd0;
            k_q       <= 1'b0;
            bcast_q   <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            tx_data_q <= 16'd0;
            tx_cd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            sa_q      <= sa_d;
            k_q       <= k_d;
            bcast_q   <= bcast_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            tx_cd_q   <= tx_cd_d;
        end
    end

    assign tx_data  = tx_data_d;
    assign tx_cd    = tx_cd_d;
    assign tx_ready = tx_ready_d && !reset;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign msg_done = (state_q == ST_DONE);
    assign msg_err  = err_q;
    assign msg_sa   = sa_q;
    assign msg_wc   = cnt_q;

    mkio_rt_buf #(.DEPTH(SA_NUM * 32), .AW(AW)) u_rx_buf (
        .clk   (clk),
        .reset (reset),
        .we    (rx_we),
        .waddr (buf_addr),
        .wdata (rx_data),
        .raddr (host_addr),
        .rdata (host_rdata)
    );

    mkio_rt_buf #(.DEPTH(SA_NUM * 32), .AW(AW)) u_tx_buf (
        .clk   (clk),
        .reset (reset),
        .we    (host_we),
        .waddr (host_addr),
        .wdata (host_wdata),
        .raddr (buf_addr),
        .rdata (tx_rdata)
    );

endmodule

// File: tb/tb_mkio_rt_responder.sv
// Directed self-checking bench for mkio_rt_responder with a simple encoder
// model that holds tx_busy for a fixed number of cycles after each tx_ready.
module tb_mkio_rt_responder;

    localparam int GAP = 4;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid, rx_cd, p_error;
    logic [15:0] rx_data;
    logic [15:0] tx_data;
    logic        tx_cd, tx_ready;
    logic        tx_busy;
    logic [6:0]  host_addr;
    logic        host_we;
    logic [15:0] host_wdata, host_rdata;
    logic        busy, msg_done, msg_err;
    logic [4:0]  msg_sa;
    logic [5:0]  msg_wc;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int busy_viol = 0;
    int enc_len = 2;
    int busy_cnt = 0;
    int strobe_cyc = 0;
    logic [16:0] words[$];
    int          ready_cyc[$];
    logic [11:0] dones[$];

    mkio_rt_responder #(
        .ADDRESS(5'd1), .SA_NUM(4), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .BCAST_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_cd(rx_cd), .p_error(p_error),
        .tx_data(tx_data), .tx_cd(tx_cd), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .busy(busy), .msg_done(msg_done), .msg_err(msg_err), .msg_sa(msg_sa), .msg_wc(msg_wc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Encoder model and output monitor: sample mid-cycle, update tx_busy just after the edge.
    initial begin
        logic fire;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            fire = tx_ready;
            if (tx_ready) begin
                if (tx_busy) busy_viol++;
                words.push_back({tx_cd, tx_data});
                ready_cyc.push_back(cycle);
            end
            if (msg_done) dones.push_back({msg_err, msg_sa, msg_wc});
            @(posedge clk);
            #1;
            if (fire && enc_len > 0) begin
                tx_busy  = 1'b1;
                busy_cnt = enc_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] w, input logic cd, input logic perr);
        rx_valid   = 1'b1;
        rx_data    = w;
        rx_cd      = cd;
        p_error    = perr;
        strobe_cyc = cycle;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
        rx_cd    = 1'b0;
        p_error  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clearLogs();
        words.delete();
        ready_cyc.delete();
        dones.delete();
    endtask

    task automatic waitDone(input int budget);
        int got = 0;
        for (int i = 0; i < budget; i++) begin
            if (dones.size() != 0) begin
                got = 1;
                break;
            end
            idle(1);
        end
        idle(4);
        checkOutput("done_wait", got, 1);
    endtask

    task automatic hostRead(input logic [6:0] a, output logic [15:0] d);
        host_addr = a;
        idle(1);
        d = host_rdata;
    endtask

    function automatic logic [16:0] getWord(input int i);
        return (words.size() > i) ? words[i] : 17'h1ffff;
    endfunction

    function automatic int getCyc(input int i);
        return (ready_cyc.size() > i) ? ready_cyc[i] : -1000;
    endfunction

    function automatic logic [11:0] getDone(input int i);
        return (dones.size() > i) ? dones[i] : 12'hfff;
    endfunction

    initial begin
        logic [15:0] rd;
        int last;
        int errs;
        int n_before;

        reset = 1'b1; rx_valid = 1'b0; rx_cd = 1'b0; rx_data = 16'd0; p_error = 1'b0;
        host_we = 1'b0; host_addr = 7'd0; host_wdata = 16'd0;
        idle(3);
        checkOutput("rst_tx_data", tx_data, 16'h0000);
        checkOutput("rst_tx_cd_ready", {tx_cd, tx_ready}, 2'b00);
        checkOutput("rst_busy_done", {busy, msg_done}, 2'b00);
        checkOutput("rst_msg", {msg_err, msg_sa, msg_wc}, 12'h000);
        checkOutput("rst_host_rdata", host_rdata, 16'h0000);
        reset = 1'b0;
        idle(1);

        $display("[TB] receive 3 words");
        clearLogs();
        applyStimulus(16'h0823, 1'b1, 1'b0);
        checkOutput("rx_busy_latency", busy, 1'b1);
        applyStimulus(16'hAAAA, 1'b0, 1'b0);
        applyStimulus(16'hBBBB, 1'b0, 1'b0);
        applyStimulus(16'hCCCC, 1'b0, 1'b0);
        last = strobe_cyc;
        waitDone(100);
        checkOutput("rx_sw_count", words.size(), 1);
        checkOutput("rx_sw_word", getWord(0), {1'b0, 16'h0800});
        checkOutput("rx_sw_latency", getCyc(0) - last, GAP + 1);
        checkOutput("rx_done", getDone(0), {1'b0, 5'd1, 6'd3});
        hostRead(7'd0, rd); checkOutput("rx_host_w0", rd, 16'hAAAA);
        hostRead(7'd1, rd); checkOutput("rx_host_w1", rd, 16'hBBBB);
        hostRead(7'd2, rd); checkOutput("rx_host_w2", rd, 16'hCCCC);

        $display("[TB] transmit 32 words");
        for (int i = 0; i < 32; i++) begin
            host_we    = 1'b1;
            host_addr  = {2'd1, 5'(i)};
            host_wdata = 16'(i);
            idle(1);
        end
        host_we = 1'b0;
        clearLogs();
        applyStimulus(16'h0C40, 1'b1, 1'b0);
        waitDone(600);
        checkOutput("tx_word_count", words.size(), 33);
        checkOutput("tx_sw_word", getWord(0), {1'b0, 16'h0800});
        checkOutput("tx_first_data", getWord(1), {1'b1, 16'h0000});
        checkOutput("tx_last_data", getWord(32), {1'b1, 16'h001F});
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            if (getWord(i + 1) !== {1'b1, 16'(i)}) errs++;
        end
        checkOutput("tx_data_errors", errs, 0);
        errs = 0;
        for (int i = 1; i <= 32; i++) begin
            if (getCyc(i) - getCyc(i - 1) != enc_len + 3) errs++;
        end
        checkOutput("tx_spacing_errors", errs, 0);
        checkOutput("tx_ready_while_busy", busy_viol, 0);
        checkOutput("tx_done", getDone(0), {1'b0, 5'd2, 6'd32});

        $display("[TB] parity error on data word 2");
        clearLogs();
        applyStimulus(16'h0823, 1'b1, 1'b0);
        applyStimulus(16'h1111, 1'b0, 1'b0);
        applyStimulus(16'h2222, 1'b0, 1'b1);
        applyStimulus(16'h3333, 1'b0, 1'b0);
        waitDone(100);
        checkOutput("perr_sw_word", getWord(0), {1'b0, 16'h0C00});
        checkOutput("perr_done", getDone(0), {1'b1, 5'd1, 6'd3});
        hostRead(7'd1, rd); checkOutput("perr_word_stored", rd, 16'h2222);

        $display("[TB] broadcast receive");
        clearLogs();
        applyStimulus(16'hF822, 1'b1, 1'b0);
        applyStimulus(16'h5555, 1'b0, 1'b0);
        applyStimulus(16'h6666, 1'b0, 1'b0);
        waitDone(100);
        idle(10);
        checkOutput("bcast_no_status", words.size(), 0);
        checkOutput("bcast_done", getDone(0), {1'b0, 5'd1, 6'd2});
        hostRead(7'd0, rd); checkOutput("bcast_host_w0", rd, 16'h5555);

        $display("[TB] data word timeout");
        clearLogs();
        applyStimulus(16'h0824, 1'b1, 1'b0);
        applyStimulus(16'h1234, 1'b0, 1'b0);
        applyStimulus(16'h5678, 1'b0, 1'b0);
        waitDone(TMO + 40);
        checkOutput("tmo_no_status", words.size(), 0);
        checkOutput("tmo_done", getDone(0), {1'b1, 5'd1, 6'd2});

        $display("[TB] command supersession");
        clearLogs();
        applyStimulus(16'h0824, 1'b1, 1'b0);
        applyStimulus(16'h7777, 1'b0, 1'b0);
        applyStimulus(16'h0861, 1'b1, 1'b0);
        applyStimulus(16'h9999, 1'b0, 1'b0);
        waitDone(100);
        checkOutput("sup_done_count", dones.size(), 1);
        checkOutput("sup_done", getDone(0), {1'b0, 5'd3, 6'd1});
        checkOutput("sup_sw_word", getWord(0), {1'b0, 16'h0800});
        hostRead(7'd64, rd); checkOutput("sup_host_sa3", rd, 16'h9999);

        $display("[TB] illegal subaddress 0");
        clearLogs();
        applyStimulus(16'h0801, 1'b1, 1'b0);
        last = strobe_cyc;
        waitDone(100);
        checkOutput("ill_word_count", words.size(), 1);
        checkOutput("ill_sw_word", getWord(0), {1'b0, 16'h0C00});
        checkOutput("ill_sw_latency", getCyc(0) - last, GAP + 1);
        checkOutput("ill_done", getDone(0), {1'b1, 5'd0, 6'd0});

        $display("[TB] reset during transmit");
        clearLogs();
        applyStimulus(16'h0C40, 1'b1, 1'b0);
        errs = 1;
        for (int i = 0; i < 200; i++) begin
            if (words.size() >= 4) begin
                errs = 0;
                break;
            end
            idle(1);
        end
        checkOutput("rst_tx_progress", errs, 0);
        reset = 1'b1;
        n_before = words.size();
        idle(1);
        checkOutput("rst_mid_tx_data", tx_data, 16'h0000);
        checkOutput("rst_mid_ready_cd", {tx_ready, tx_cd}, 2'b00);
        checkOutput("rst_mid_busy_done", {busy, msg_done}, 2'b00);
        checkOutput("rst_mid_msg", {msg_err, msg_sa, msg_wc}, 12'h000);
        reset = 1'b0;
        idle(30);
        checkOutput("rst_no_more_ready", words.size(), n_before);
        checkOutput("rst_no_done", dones.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
